// File: rtl/cache_bus_pkg.sv
// rtl/cache_bus_pkg.sv - shared constants for the cache<->SDRAM request bus
// Holds the line geometry, byte-enable encodings and the responder state
// encoding. The cache side of the bus imports this package as well.
package cache_bus_pkg;

    localparam int BURST_LOG2  = 2;
    localparam int BURST_WORDS = 1 << BURST_LOG2;

    localparam logic [1:0] BE_WORD  = 2'b11;
    localparam logic [1:0] BE_UPPER = 2'b10;
    localparam logic [1:0] BE_LOWER = 2'b01;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_FILL     = 3'd3;
    localparam logic [2:0] ST_WR_ISSUE = 3'd4;
    localparam logic [2:0] ST_WR_DONE  = 3'd5;

endpackage

// File: rtl/cache_fill_responder_if.sv
// rtl/cache_fill_responder_if.sv - cache request bus and word backend bus
// cache_sdram_if: cache (master) <-> responder (slave)
//   cache_addr/req/rw/wdata/be toward the responder,
//   cache_rdata/fill/wack back to the cache.
// mem_word_if: responder (master) <-> pipelined word backend (slave)
//   mem_req/we/addr/be/wdata toward the backend,
//   mem_ack/rvalid/rdata back to the responder.
interface cache_sdram_if #(parameter int ADDR_WIDTH = 32);
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic                  cache_req;
    logic                  cache_rw;
    logic [15:0]           cache_wdata;
    logic [1:0]            cache_be;
    logic [15:0]           cache_rdata;
    logic                  cache_fill;
    logic                  cache_wack;

    modport master (
        output cache_addr, cache_req, cache_rw, cache_wdata, cache_be,
        input  cache_rdata, cache_fill, cache_wack
    );
    modport slave (
        input  cache_addr, cache_req, cache_rw, cache_wdata, cache_be,
        output cache_rdata, cache_fill, cache_wack
    );
endinterface

interface mem_word_if #(parameter int ADDR_WIDTH = 32);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [1:0]            mem_be;
    logic [15:0]           mem_wdata;
    logic                  mem_ack;
    logic                  mem_rvalid;
    logic [15:0]           mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/cache_fill_responder_buf.sv
// rtl/cache_fill_responder_buf.sv - line buffer holding one fill burst
// Ports: clk; wr_en_i/wr_idx_i/wr_data_i write one word per cycle;
// rd_idx_i selects the word presented combinationally on rd_data_o.
module fill_line_buffer #(
    parameter int WORDS_LOG2 = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [WORDS_LOG2-1:0] wr_idx_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [WORDS_LOG2-1:0] rd_idx_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] words_q [0:(1 << WORDS_LOG2)-1];

    // Contents need no reset: a word is always written before it is read.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            words_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = words_q[rd_idx_i];

endmodule

// File: rtl/cache_fill_responder.sv
// rtl/cache_fill_responder.sv - serves cache line fills and word writes from a word backend
// Ports: clk, reset (async, active-high); cache (cache_sdram_if.slave);
// mem (mem_word_if.master); busy high whenever not idle.
// A read issues one backend read per word, gathers the in-order returns
// into the line buffer, then plays them out as a contiguous fill burst.
module cache_fill_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_sdram_if.slave         cache,
    mem_word_if.master           mem,
    output logic                 busy
);
    import cache_bus_pkg::*;

    localparam int LINE_WORDS = 1 << BURST_LOG2;
    localparam int CNT_W      = BURST_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]      rcv_cnt_q, rcv_cnt_d;
    logic [CNT_W-1:0]      fill_cnt_q, fill_cnt_d;

    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]            mem_be_q, mem_be_d;
    logic [15:0]           mem_wdata_q, mem_wdata_d;
    logic [15:0]           cache_rdata_q, cache_rdata_d;
    logic                  cache_fill_q, cache_fill_d;
    logic                  cache_wack_q, cache_wack_d;
    logic                  busy_q, busy_d;

    logic                  capture;
    logic [15:0]           buf_rdata;

    // Returns are only meaningful while a read is outstanding; anything
    // arriving elsewhere, or past the end of the line, is dropped.
    assign capture = ((state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT)) &&
                     mem.mem_rvalid && (rcv_cnt_q < CNT_FULL);

    fill_line_buffer #(
        .WORDS_LOG2 (BURST_LOG2),
        .DATA_WIDTH (16)
    ) u_line_buf (
        .clk       (clk),
        .wr_en_i   (capture),
        .wr_idx_i  (rcv_cnt_q[BURST_LOG2-1:0]),
        .wr_data_i (mem.mem_rdata),
        .rd_idx_i  (fill_cnt_q[BURST_LOG2-1:0]),
        .rd_data_o (buf_rdata)
    );

    always_comb begin
        state_d       = state_q;
        issue_cnt_d   = issue_cnt_q;
        rcv_cnt_d     = capture ? rcv_cnt_q + 1'b1 : rcv_cnt_q;
        fill_cnt_d    = fill_cnt_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        cache_rdata_d = '0;
        cache_fill_d  = 1'b0;
        cache_wack_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cache.cache_req) begin
                    mem_req_d = 1'b1;
                    if (cache.cache_rw) begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = cache.cache_addr & ~ADDR_WIDTH'(2 * LINE_WORDS - 1);
                        mem_be_d    = BE_WORD;
                        mem_wdata_d = '0;
                        state_d     = ST_RD_ISSUE;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cache.cache_addr & ~ADDR_WIDTH'(1);
                        mem_be_d    = cache.cache_be;
                        mem_wdata_d = cache.cache_wdata;
                        state_d     = ST_WR_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                if (mem.mem_ack) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == CNT_LAST) begin
                        mem_req_d = 1'b0;
                        state_d   = (rcv_cnt_d == CNT_FULL) ? ST_FILL : ST_RD_WAIT;
                    end else begin
                        mem_addr_d = mem_addr_q + ADDR_WIDTH'(2);
                    end
                end
            end
            ST_RD_WAIT: begin
                if (rcv_cnt_d == CNT_FULL) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                // One extra cycle in FILL drives the bus back to zero after
                // the last word, so the burst itself is never split.
                if (fill_cnt_q == CNT_FULL) begin
                    issue_cnt_d = '0;
                    rcv_cnt_d   = '0;
                    fill_cnt_d  = '0;
                    state_d     = ST_IDLE;
                end else begin
                    cache_rdata_d = buf_rdata;
                    cache_fill_d  = (fill_cnt_q == '0);
                    fill_cnt_d    = fill_cnt_q + 1'b1;
                end
            end
            ST_WR_ISSUE: begin
                if (mem.mem_ack) begin
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    cache_wack_d = 1'b1;
                    state_d      = ST_WR_DONE;
                end
            end
            ST_WR_DONE: begin
                // A still-held request is the one just serviced.
                if (!cache.cache_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            issue_cnt_q   <= '0;
            rcv_cnt_q     <= '0;
            fill_cnt_q    <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= '0;
            mem_wdata_q   <= '0;
            cache_rdata_q <= '0;
            cache_fill_q  <= 1'b0;
            cache_wack_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_cnt_q   <= issue_cnt_d;
            rcv_cnt_q     <= rcv_cnt_d;
            fill_cnt_q    <= fill_cnt_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            cache_rdata_q <= cache_rdata_d;
            cache_fill_q  <= cache_fill_d;
            cache_wack_q  <= cache_wack_d;
            busy_q        <= busy_d;
        end
    end

    assign cache.cache_rdata = cache_rdata_q;
    assign cache.cache_fill  = cache_fill_q;
    assign cache.cache_wack  = cache_wack_q;
    assign mem.mem_req       = mem_req_q;
    assign mem.mem_we        = mem_we_q;
    assign mem.mem_addr      = mem_addr_q;
    assign mem.mem_be        = mem_be_q;
    assign mem.mem_wdata     = mem_wdata_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_cache_fill_responder.sv
// tb/tb_cache_fill_responder.sv - self-checking bench for cache_fill_responder
module tb_cache_fill_responder;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    always #5 clk = ~clk;

    cache_sdram_if #(.ADDR_WIDTH(32)) cache_bus ();
    mem_word_if    #(.ADDR_WIDTH(32)) mem_bus ();

    cache_fill_responder #(
        .ADDR_WIDTH (32),
        .BURST_LOG2 (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cache (cache_bus),
        .mem   (mem_bus),
        .busy  (busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Backend model: the word at byte address A holds A[15:0].
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] issued_q[$];
    int          gap = 0;
    int          lat = 1;
    int          stall_cnt = 0;
    bit          stray_rv = 1'b0;
    int          stable_err = 0;
    int          wr_count = 0;
    logic [31:0] wr_addr;
    logic [1:0]  wr_be;
    logic [15:0] wr_data;
    logic [1:0]  rd_be;
    bit          prev_req = 1'b0;
    bit          prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        mem_bus.mem_ack    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = 16'h0;
        if (stray_rv) begin
            mem_bus.mem_rvalid = 1'b1;
            mem_bus.mem_rdata  = 16'hBEEF;
        end
        if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
            mem_bus.mem_rvalid = 1'b1;
            mem_bus.mem_rdata  = pend_q[0].addr[15:0];
            void'(pend_q.pop_front());
        end
        if (mem_bus.mem_req === 1'b1) begin
            if (prev_req && !prev_ack && mem_bus.mem_addr !== prev_addr) stable_err++;
            if (stall_cnt >= gap) begin
                mem_bus.mem_ack = 1'b1;
                stall_cnt = 0;
                if (mem_bus.mem_we) begin
                    wr_count++;
                    wr_addr = mem_bus.mem_addr;
                    wr_be   = mem_bus.mem_be;
                    wr_data = mem_bus.mem_wdata;
                end else begin
                    issued_q.push_back(mem_bus.mem_addr);
                    rd_be = mem_bus.mem_be;
                    pend_q.push_back('{mem_bus.mem_addr, cyc + lat});
                end
            end else begin
                stall_cnt++;
            end
        end else begin
            stall_cnt = 0;
        end
        prev_req  = (mem_bus.mem_req === 1'b1);
        prev_ack  = mem_bus.mem_ack;
        prev_addr = mem_bus.mem_addr;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Results gathered by the transaction tasks.
    int          fill_rel, idle_rel, extra_fill, wack_rel, wack_cnt, wr_delta;
    logic [15:0] rd_data [4];
    logic [15:0] after_rdata;

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            if (cache_bus.cache_fill) extra_fill++;
            if (cache_bus.cache_wack) wack_cnt++;
            n++;
        end
        if (busy) fail_now(name);
    endtask

    // Starts and ends on a falling edge with the DUT idle.
    task automatic run_read(input string name, input logic [31:0] addr, input int g, input int l);
        int c;
        gap = g;
        lat = l;
        issued_q.delete();
        stable_err = 0;
        extra_fill = 0;
        wack_cnt = 0;
        fill_rel = -1;
        c = cyc;
        cache_bus.cache_req   = 1'b1;
        cache_bus.cache_rw    = 1'b1;
        cache_bus.cache_addr  = addr;
        cache_bus.cache_wdata = 16'h0;
        cache_bus.cache_be    = 2'b00;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (cache_bus.cache_fill) begin
                fill_rel = cyc - c - 1;
                break;
            end
        end
        if (fill_rel < 0) begin
            fail_now({name, "_fill"});
            cache_bus.cache_req = 1'b0;
            return;
        end
        rd_data[0] = cache_bus.cache_rdata;
        cache_bus.cache_req = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            rd_data[k] = cache_bus.cache_rdata;
            if (cache_bus.cache_fill) extra_fill++;
        end
        wait_idle({name, "_idle"});
        idle_rel = cyc - c - 1;
        after_rdata = cache_bus.cache_rdata;
    endtask

    task automatic run_write(input string name, input logic [31:0] addr, input logic [15:0] wd,
                             input logic [1:0] be, input int g, input int hold);
        int c;
        int w0;
        gap = g;
        w0 = wr_count;
        wack_cnt = 0;
        wack_rel = -1;
        extra_fill = 0;
        c = cyc;
        cache_bus.cache_req   = 1'b1;
        cache_bus.cache_rw    = 1'b0;
        cache_bus.cache_addr  = addr;
        cache_bus.cache_wdata = wd;
        cache_bus.cache_be    = be;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (cache_bus.cache_wack) begin
                wack_rel = cyc - c - 1;
                wack_cnt = 1;
                break;
            end
        end
        if (wack_rel < 0) fail_now({name, "_wack"});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (cache_bus.cache_wack) wack_cnt++;
        end
        cache_bus.cache_req = 1'b0;
        wait_idle({name, "_idle"});
        wr_delta = wr_count - w0;
    endtask

    task automatic check_read_line(input string name, input logic [31:0] base);
        logic [31:0] a;
        check({name, "_issue_count"}, 64'(issued_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            a = base + 32'(2 * k);
            if (k < issued_q.size()) check($sformatf("%s_addr%0d", name, k), 64'(issued_q[k]), 64'(a));
            check($sformatf("%s_data%0d", name, k), 64'(rd_data[k]), 64'(a[15:0]));
        end
        check({name, "_single_fill"}, 64'(extra_fill), 64'd0);
        check({name, "_rdata_after"}, 64'(after_rdata), 64'd0);
        check({name, "_rd_be"}, 64'(rd_be), 64'h3);
    endtask

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          gap;
        int          lat;
        int          hold;
        int          exp_lat;
        int          exp_idle;
        logic [31:0] exp_a0;
        logic [1:0]  exp_be;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [63:0] out_bits();
        return {32'h0, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be, cache_bus.cache_fill,
                cache_bus.cache_wack, busy, 1'b0, 8'h0, cache_bus.cache_rdata} |
               {mem_bus.mem_addr, 16'h0, mem_bus.mem_wdata};
    endfunction

    initial begin
        vecs[0] = '{1'b1, 32'h0000_1236, 16'h0000, 2'b00, 0, 1, 0,  6, 10, 32'h0000_1230, 2'b11};
        vecs[1] = '{1'b1, 32'h0000_4008, 16'h0000, 2'b00, 3, 5, 0, 22, 26, 32'h0000_4008, 2'b11};
        vecs[2] = '{1'b1, 32'h0000_0A27, 16'h0000, 2'b00, 0, 3, 0,  8, 12, 32'h0000_0A20, 2'b11};
        vecs[3] = '{1'b0, 32'h0000_0101, 16'hABCD, 2'b10, 0, 1, 5,  1,  0, 32'h0000_0100, 2'b10};
        vecs[4] = '{1'b1, 32'hFFFF_FFFE, 16'h0000, 2'b00, 0, 1, 0,  6, 10, 32'hFFFF_FFF8, 2'b11};
        vecs[5] = '{1'b0, 32'h0000_2000, 16'h1234, 2'b11, 2, 1, 0,  3,  0, 32'h0000_2000, 2'b11};
        vecs[6] = '{1'b0, 32'h0000_0302, 16'h5555, 2'b00, 0, 1, 1,  1,  0, 32'h0000_0302, 2'b00};
        vecs[7] = '{1'b1, 32'h0000_0303, 16'h0000, 2'b00, 1, 2, 0, 11, 15, 32'h0000_0300, 2'b11};

        reset = 1'b1;
        cache_bus.cache_req   = 1'b0;
        cache_bus.cache_rw    = 1'b0;
        cache_bus.cache_addr  = '0;
        cache_bus.cache_wdata = '0;
        cache_bus.cache_be    = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_bits(), 64'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outputs", out_bits(), 64'h0);

        // Back-to-back table: each transaction starts on the cycle the
        // previous one returns to idle (read->write and write->read pairs).
        for (int i = 0; i < 8; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            if (vecs[i].is_rd) begin
                run_read(nm, vecs[i].addr, vecs[i].gap, vecs[i].lat);
                check({nm, "_fill_lat"}, 64'(fill_rel), 64'(vecs[i].exp_lat));
                check({nm, "_idle_lat"}, 64'(idle_rel), 64'(vecs[i].exp_idle));
                check({nm, "_addr_stable"}, 64'(stable_err), 64'd0);
                check_read_line(nm, vecs[i].exp_a0);
            end else begin
                run_write(nm, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].gap, vecs[i].hold);
                check({nm, "_wack_lat"}, 64'(wack_rel), 64'(vecs[i].exp_lat));
                check({nm, "_wack_pulses"}, 64'(wack_cnt), 64'd1);
                check({nm, "_backend_writes"}, 64'(wr_delta), 64'd1);
                check({nm, "_wr_addr"}, 64'(wr_addr), 64'(vecs[i].exp_a0));
                check({nm, "_wr_be"}, 64'(wr_be), 64'(vecs[i].exp_be));
                check({nm, "_wr_data"}, 64'(wr_data), 64'(vecs[i].wdata));
            end
        end

        // Reset after the second backend ack; two returns still in flight.
        begin
            int quiet_bad;
            gap = 0;
            lat = 3;
            cache_bus.cache_req  = 1'b1;
            cache_bus.cache_rw   = 1'b1;
            cache_bus.cache_addr = 32'h0000_0554;
            repeat (3) @(posedge clk);
            #1;
            reset = 1'b1;
            cache_bus.cache_req = 1'b0;
            #1;
            check("midread_reset_outputs", out_bits(), 64'h0);
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
            quiet_bad = 0;
            repeat (6) begin
                @(negedge clk);
                if (cache_bus.cache_fill || busy || mem_bus.mem_req) quiet_bad++;
            end
            check("late_returns_ignored", 64'(quiet_bad), 64'd0);
            check("late_returns_drained", 64'(pend_q.size()), 64'd0);
            run_read("after_reset", 32'h0000_0C44, 0, 1);
            check("after_reset_fill_lat", 64'(fill_rel), 64'd6);
            check_read_line("after_reset", 32'h0000_0C40);
        end

        // Stray return while idle.
        begin
            int quiet_bad;
            @(posedge clk);
            stray_rv = 1'b1;
            @(posedge clk);
            stray_rv = 1'b0;
            quiet_bad = 0;
            repeat (4) begin
                @(negedge clk);
                if (cache_bus.cache_fill || busy) quiet_bad++;
            end
            check("stray_rvalid_quiet", 64'(quiet_bad), 64'd0);
            run_read("after_stray", 32'h0000_003A, 0, 1);
            check("after_stray_fill_lat", 64'(fill_rel), 64'd6);
            check_read_line("after_stray", 32'h0000_0038);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_fill_responder.md
# cache_fill_responder

Memory-side responder for the cache↔SDRAM request interface.
- Accepts a line-fill read or single-word write from the two-way cache's SDRAM port.
- Performs a read by issuing individual word reads to a pipelined word-wide memory backend and collecting the results.
- Returns a read to the cache as the fill burst the cache expects: a one-cycle `cache_fill` strobe carrying word 0, followed by words 1–3 on the three consecutive cycles.
- Sits between the cache and the SDRAM controller, or stands in for the controller on block-RAM systems.

## Interface
Parameters
- `ADDR_WIDTH`, 32, width of cache and backend byte addresses.
- `BURST_LOG2`, 2, log2 of words per line. `BURST_WORDS = 1<<BURST_LOG2`; the cache requires 4.

Ports
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-high. Clears all state and outputs.
- `cache_addr` in ADDR_WIDTH: request byte address. Bits [BURST_LOG2:0] are ignored for reads; bit 0 is ignored for writes.
- `cache_req` in 1: level request, held by the cache until serviced.
- `cache_rw` in 1: 1 = line read, 0 = word write.
- `cache_wdata` in 16: write data.
- `cache_be` in 2: byte enables, [1] upper, [0] lower, active-high.
- `cache_rdata` out 16: fill data. 0 outside the fill window.
- `cache_fill` out 1: one-cycle strobe, high with word 0.
- `cache_wack` out 1: one-cycle write-complete pulse.
- `busy` out 1: high in every state except IDLE.
- `mem_req` out 1: backend request, held until `mem_ack`.
- `mem_we` out 1: backend write.
- `mem_addr` out ADDR_WIDTH: backend byte address, bit 0 = 0.
- `mem_be` out 2: backend byte enables.
- `mem_wdata` out 16: backend write data.
- `mem_ack` in 1: request accepted this cycle.
- `mem_rvalid` in 1: read data valid. Returns are in issue order, latency ≥1, multiple reads may be outstanding.
- `mem_rdata` in 16: read data.

## Operation
- All outputs are registered; every output resets to 0.
- States: IDLE, RD_ISSUE, RD_WAIT, FILL, WR_ISSUE, WR_DONE.
- **IDLE**
  - On `cache_req=1`, latch address, rw, wdata and be.
  - Read → RD_ISSUE, with base = addr & ~(2*BURST_WORDS-1).
  - Write → WR_ISSUE.
- **RD_ISSUE**
  - Drive `mem_req=1`, `mem_we=0`, `mem_addr = base + 2*issue_cnt`, `mem_be=2'b11`.
  - Increment `issue_cnt` on each `mem_ack`.
  - Go to RD_WAIT after the BURST_WORDS-th ack, or directly to FILL if all data has already returned.
- **Read-data capture (RD_ISSUE and RD_WAIT)**
  - Every `mem_rvalid` writes `buf[rcv_cnt]` and increments `rcv_cnt`.
  - `rvalid` arriving in the same cycle as an `ack` is legal.
- **RD_WAIT**: on `rcv_cnt` reaching BURST_WORDS → FILL.
- **FILL**
  - Lasts exactly BURST_WORDS cycles; `cache_rdata = buf[k]`, k = 0..3, in ascending address order.
  - `cache_fill=1` only while k=0.
  - → IDLE after k=3; counters clear.
- **WR_ISSUE**
  - Drive `mem_req=1`, `mem_we=1`, `mem_addr` = latched address with bit 0 = 0, `mem_be`, `mem_wdata`.
  - On `mem_ack` → WR_DONE, and pulse `cache_wack` for one cycle.
- **WR_DONE**: wait for `cache_req=0`, then → IDLE. This prevents a held write request being serviced twice.
- Unexpected backend returns: `mem_rvalid` in IDLE, WR_*, FILL, or beyond BURST_WORDS is ignored.
- `cache_be=2'b00` write: still issued to the backend and still acknowledged.
- `mem_req` stays asserted and stable while `mem_ack=0` (backpressure).

## Timing
- Request sampling: `cache_req` is sampled in IDLE. The first `mem_req` is high the cycle after sampling.
- Read latency (zero-wait backend, rvalid 1 cycle after ack):
  - Request sampled at edge 0; acks at edges 1–4; rvalid at edges 2–5.
  - `cache_fill` high during the cycle after edge 6, with words at edges 6–9 outputs.
  - IDLE resumes at edge 10.
- Fill contiguity: the fill burst is never interrupted; backend stalls only delay its start.
- Cache request drop: the cache drops `cache_req` on seeing `cache_fill`. It is low by the time IDLE resumes, so no repeat read occurs.
- Write latency: `cache_wack` is asserted the cycle after `mem_ack`.
- Asynchronous reset mid-operation: returns to IDLE, clears the buffer index and counters, and drops `mem_req`/`cache_fill` immediately. In-flight backend returns after reset are discarded.
- Address wrap: base + 6 wraps modulo 2^ADDR_WIDTH without error.

## Structure
- Shared package `cache_bus_pkg`:
  - State encoding.
  - `BURST_LOG2` / `BURST_WORDS`.
  - Byte-enable constants `BE_WORD=2'b11`, `BE_UPPER=2'b10`, `BE_LOWER=2'b01`.
  - This package is also used by the cache.
- Sub-module `fill_line_buffer`: BURST_WORDS×16 register file with write-index and read-index ports.
- The FSM, counters and latches stay in the top module.

## Test plan
- Line read, zero-wait backend, memory word at byte addr A holds A[15:0], request addr 0x0000_1236:
  - `mem_addr` sequence 0x1230, 0x1232, 0x1234, 0x1236.
  - `cache_fill` for 1 cycle with 0x1230, then 0x1232, 0x1234, 0x1236.
  - `busy` low 10 edges after request.
- Backend stalls: `mem_ack` low 3 cycles between issues, rvalid latency 5:
  - `mem_addr` holds steady during the stall.
  - The fill is still 4 contiguous cycles with the correct order.
- Upper-byte write, addr 0x0000_0101, wdata 0xABCD, be=2'b10:
  - `mem_addr`=0x0100, `mem_be`=2'b10, `mem_we`=1.
  - One `cache_wack` pulse.
  - `cache_req` held 5 more cycles → exactly one backend write.
- Read followed immediately by write (req re-asserted the cycle after IDLE):
  - Both are serviced in order.
  - No spurious `mem_rvalid` capture.
- Reset asserted after the second `mem_ack` of a read:
  - All outputs 0 immediately.
  - Two late rvalids are ignored.
  - The next read returns correct data.
- Stray `mem_rvalid` in IDLE:
  - No `cache_fill`, buffer unchanged.
  - The following read returns correct data.
